// File: rtl/difftest_sim_ctrl_pkg.sv
// Shared types for the difftest simulation controller: FSM state encoding
// and finish-code constants.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        WAIT,
        DONE
    } state_e;

    localparam logic [1:0] FIN_NONE    = 2'd0;
    localparam logic [1:0] FIN_FAIL    = 2'd1;
    localparam logic [1:0] FIN_TIMEOUT = 2'd2;

endpackage

// File: rtl/difftest_step_accum.sv
// Per-core difftest_step delay register plus a sticky pending accumulator.
// 'take' hands the current pending set to a request; 'clr' discards everything.
module difftest_step_accum #(
    parameter int NUM_CORES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 take,
    input  logic [NUM_CORES-1:0] step_in,
    output logic [NUM_CORES-1:0] pending
);

    logic [NUM_CORES-1:0] step_dly_q, step_dly_d;
    logic [NUM_CORES-1:0] pending_q,  pending_d;

    always_comb begin
        step_dly_d = clr ? '0 : step_in;
        // A step arriving in the take cycle belongs to the next request.
        if (clr)       pending_d = '0;
        else if (take) pending_d = step_dly_q;
        else           pending_d = pending_q | step_dly_q;
    end

    // NOTE: sequential state is written only with non-blocking '<=' so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_dly_q <= '0;
            pending_q  <= '0;
        end else begin
            step_dly_q <= step_dly_d;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/difftest_sim_ctrl.sv
// Difftest simulation controller: init handshake, batched step-check requests,
// DUT stall, cycle/log/timeout tracking. Optional SIM_CTRL_PERF_EN adds perf counters.
module difftest_sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int NUM_CORES        = 1,
    parameter int CYCLE_W          = 64,
    parameter int STALL_ON_PENDING = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [CYCLE_W-1:0]   cfg_max_cycles,
    input  logic [CYCLE_W-1:0]   cfg_log_begin,
    input  logic [CYCLE_W-1:0]   cfg_log_end,
    input  logic [NUM_CORES-1:0] difftest_step,
    output logic                 init_req,
    input  logic                 init_ack,
    output logic                 step_req,
    output logic [NUM_CORES-1:0] step_mask,
    input  logic                 step_ack,
    input  logic                 step_fail,
    output logic                 dut_stall,
    output logic                 log_enable,
    output logic [CYCLE_W-1:0]   cycle_count,
    output logic                 finish,
    output logic [1:0]           finish_code,
    output logic [CYCLE_W-1:0]   fail_cycle
`ifdef SIM_CTRL_PERF_EN
    ,
    output logic [CYCLE_W-1:0]   perf_stall_cycles,
    output logic [31:0]          perf_step_reqs
`endif
);

    state_e               state_q, state_d;
    logic                 init_req_q, init_req_d;
    logic                 step_req_q, step_req_d;
    logic [NUM_CORES-1:0] step_mask_q, step_mask_d;
    logic                 dut_stall_q, dut_stall_d;
    logic                 log_enable_q, log_enable_d;
    logic [CYCLE_W-1:0]   cycle_count_q, cycle_count_d;
    logic                 finish_q, finish_d;
    logic [1:0]           finish_code_q, finish_code_d;
    logic [CYCLE_W-1:0]   fail_cycle_q, fail_cycle_d;
    logic [CYCLE_W-1:0]   req_cycle_q, req_cycle_d;

    logic [NUM_CORES-1:0] pending;
    logic                 take;
    logic                 active;
    logic                 timeout;

    difftest_step_accum #(.NUM_CORES(NUM_CORES)) u_accum (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     ((state_q == IDLE) || (state_q == INIT)),
        .take    (take),
        .step_in (difftest_step),
        .pending (pending)
    );

    assign active  = (state_q == RUN) || (state_q == WAIT);
    assign timeout = active && (cfg_max_cycles != '0) && (cycle_count_q >= cfg_max_cycles);

    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        init_req_d    = init_req_q;
        step_req_d    = step_req_q;
        step_mask_d   = step_mask_q;
        finish_code_d = finish_code_q;
        fail_cycle_d  = fail_cycle_q;
        take          = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d    = INIT;
                init_req_d = 1'b1;
            end
            INIT: begin
                if (init_ack) begin
                    state_d    = RUN;
                    init_req_d = 1'b0;
                end
            end
            RUN: begin
                if (timeout) begin
                    state_d       = DONE;
                    finish_code_d = FIN_TIMEOUT;
                end else if (pending != '0) begin
                    take        = 1'b1;
                    state_d     = WAIT;
                    step_req_d  = 1'b1;
                    step_mask_d = pending;
                end
            end
            WAIT: begin
                // A failing ack outranks a simultaneous timeout.
                if (step_ack && step_fail) begin
                    state_d       = DONE;
                    finish_code_d = FIN_FAIL;
                    fail_cycle_d  = req_cycle_q;
                end else if (timeout) begin
                    state_d       = DONE;
                    finish_code_d = FIN_TIMEOUT;
                end else if (step_ack) begin
                    state_d = RUN;
                end
                if (state_d != WAIT) begin
                    step_req_d  = 1'b0;
                    step_mask_d = '0;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        finish_d    = (state_d == DONE);
        dut_stall_d = (state_d == INIT) || (state_d == DONE) ||
                      ((state_d == WAIT) && (STALL_ON_PENDING != 0));

        cycle_count_d = cycle_count_q;
        if (active && !dut_stall_q && (state_d != DONE) && (cycle_count_q != '1))
            cycle_count_d = cycle_count_q + 1'b1;

        // req_cycle is the cycle_count value visible while the request is up.
        req_cycle_d  = take ? cycle_count_d : req_cycle_q;
        log_enable_d = (cfg_log_end != '0) && (cycle_count_q >= cfg_log_begin) &&
                       (cycle_count_q < cfg_log_end);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            init_req_q    <= 1'b0;
            step_req_q    <= 1'b0;
            step_mask_q   <= '0;
            dut_stall_q   <= 1'b0;
            log_enable_q  <= 1'b0;
            cycle_count_q <= '0;
            finish_q      <= 1'b0;
            finish_code_q <= FIN_NONE;
            fail_cycle_q  <= '0;
            req_cycle_q   <= '0;
        end else begin
            state_q       <= state_d;
            init_req_q    <= init_req_d;
            step_req_q    <= step_req_d;
            step_mask_q   <= step_mask_d;
            dut_stall_q   <= dut_stall_d;
            log_enable_q  <= log_enable_d;
            cycle_count_q <= cycle_count_d;
            finish_q      <= finish_d;
            finish_code_q <= finish_code_d;
            fail_cycle_q  <= fail_cycle_d;
            req_cycle_q   <= req_cycle_d;
        end
    end

    assign init_req    = init_req_q;
    assign step_req    = step_req_q;
    assign step_mask   = step_mask_q;
    assign dut_stall   = dut_stall_q;
    assign log_enable  = log_enable_q;
    assign cycle_count = cycle_count_q;
    assign finish      = finish_q;
    assign finish_code = finish_code_q;
    assign fail_cycle  = fail_cycle_q;

`ifdef SIM_CTRL_PERF_EN
    logic [CYCLE_W-1:0] perf_stall_q, perf_stall_d;
    logic [31:0]        perf_reqs_q,  perf_reqs_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_reqs_d  = perf_reqs_q;
        if ((state_q == WAIT) && dut_stall_q && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 1'b1;
        if (take && (perf_reqs_q != '1))
            perf_reqs_d = perf_reqs_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_reqs_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_reqs_q  <= perf_reqs_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_step_reqs    = perf_reqs_q;
`endif

endmodule

// File: tb/tb_difftest_sim_ctrl.sv
// Directed self-checking bench for difftest_sim_ctrl (NUM_CORES=2, stall on pending).
module tb_difftest_sim_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] cfg_max_cycles, cfg_log_begin, cfg_log_end;
    logic [1:0]  difftest_step;
    logic        init_req, init_ack;
    logic        step_req;
    logic [1:0]  step_mask;
    logic        step_ack, step_fail;
    logic        dut_stall, log_enable;
    logic [63:0] cycle_count;
    logic        finish;
    logic [1:0]  finish_code;
    logic [63:0] fail_cycle;
`ifdef SIM_CTRL_PERF_EN
    logic [63:0] perf_stall_cycles;
    logic [31:0] perf_step_reqs;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    difftest_sim_ctrl #(.NUM_CORES(2), .CYCLE_W(64), .STALL_ON_PENDING(1)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_max_cycles (cfg_max_cycles),
        .cfg_log_begin  (cfg_log_begin),
        .cfg_log_end    (cfg_log_end),
        .difftest_step  (difftest_step),
        .init_req       (init_req),
        .init_ack       (init_ack),
        .step_req       (step_req),
        .step_mask      (step_mask),
        .step_ack       (step_ack),
        .step_fail      (step_fail),
        .dut_stall      (dut_stall),
        .log_enable     (log_enable),
        .cycle_count    (cycle_count),
        .finish         (finish),
        .finish_code    (finish_code),
        .fail_cycle     (fail_cycle)
`ifdef SIM_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_step_reqs    (perf_step_reqs)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".init_req"},    init_req,    0);
        check({tag, ".step_req"},    step_req,    0);
        check({tag, ".step_mask"},   step_mask,   0);
        check({tag, ".dut_stall"},   dut_stall,   0);
        check({tag, ".log_enable"},  log_enable,  0);
        check({tag, ".cycle_count"}, cycle_count, 0);
        check({tag, ".finish"},      finish,      0);
        check({tag, ".finish_code"}, finish_code, 0);
        check({tag, ".fail_cycle"},  fail_cycle,  0);
    endtask

    initial begin
        reset_n        = 1'b0;
        cfg_max_cycles = '0;
        cfg_log_begin  = '0;
        cfg_log_end    = '0;
        difftest_step  = '0;
        init_ack       = 1'b0;
        step_ack       = 1'b0;
        step_fail      = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // Init handshake: ack held low for 5 cycles.
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("init.req_high", init_req, 1);
            check("init.stall", dut_stall, 1);
            check("init.cycle", cycle_count, 0);
        end
        init_ack = 1'b1;
        tick();
        init_ack = 1'b0;
        check("run.init_req_low", init_req, 0);
        check("run.stall_low", dut_stall, 0);
        check("run.cycle0", cycle_count, 0);

        // Step on core 0 at RUN cycle 3.
        tick(); tick(); tick();
        check("run.cycle3", cycle_count, 3);
        difftest_step = 2'b01;
        tick();
        difftest_step = 2'b00;
        check("step.no_req_a", step_req, 0);
        tick();
        check("step.no_req_b", step_req, 0);
        tick();
        check("step.req", step_req, 1);
        check("step.mask01", step_mask, 2'b01);
        check("step.stall", dut_stall, 1);
        check("step.cycle6", cycle_count, 6);

        // Steps during WAIT accumulate; mask and cycle_count stay frozen.
        difftest_step = 2'b10;
        tick();
        difftest_step = 2'b01;
        check("wait.mask_stable", step_mask, 2'b01);
        check("wait.cycle_frozen", cycle_count, 6);
        tick();
        difftest_step = 2'b00;
        tick();
        tick();
        check("wait.req_held", step_req, 1);
        check("wait.stall_held", dut_stall, 1);
        check("wait.cycle_still", cycle_count, 6);
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        check("ack.req_low", step_req, 0);
        check("ack.stall_low", dut_stall, 0);
        check("ack.cycle6", cycle_count, 6);
        check("ack.no_finish", finish, 0);
        tick();
        check("req2.req", step_req, 1);
        check("req2.mask11", step_mask, 2'b11);
        check("req2.cycle7", cycle_count, 7);

        // Failing ack for the request issued at cycle 7.
        step_ack  = 1'b1;
        step_fail = 1'b1;
        tick();
        step_ack  = 1'b0;
        step_fail = 1'b0;
        check("fail.finish", finish, 1);
        check("fail.code", finish_code, 1);
        check("fail.cycle", fail_cycle, 7);
        check("fail.req_low", step_req, 0);
        check("fail.init_req_low", init_req, 0);
        check("fail.stall", dut_stall, 1);
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        tick();
        check("late_ack.code", finish_code, 1);
        check("late_ack.fail_cycle", fail_cycle, 7);
        check("late_ack.finish", finish, 1);
        check("late_ack.cycle", cycle_count, 7);

        // Timeout at 10 cycles with log window [3,6).
        reset_n = 1'b0;
        #1;
        check("rst2.finish", finish, 0);
        check("rst2.code", finish_code, 0);
        check("rst2.fail_cycle", fail_cycle, 0);
        check("rst2.stall", dut_stall, 0);
        cfg_max_cycles = 64'd10;
        cfg_log_begin  = 64'd3;
        cfg_log_end    = 64'd6;
        tick();
        reset_n = 1'b1;
        tick();
        init_ack = 1'b1;
        tick();
        init_ack = 1'b0;
        check("to.cycle0", cycle_count, 0);
        check("to.log0", log_enable, 0);
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("to.cycle", cycle_count, 64'(n));
            check("to.log", log_enable, ((n - 1) >= 3 && (n - 1) < 6) ? 1 : 0);
            check("to.running", finish, 0);
        end
        tick();
        check("to.finish", finish, 1);
        check("to.code", finish_code, 2);
        check("to.cycle10", cycle_count, 10);
        check("to.stall", dut_stall, 1);
        check("to.log_off", log_enable, 0);
        tick();
        check("to.sticky", finish, 1);
        check("to.cycle_hold", cycle_count, 10);

        // Stray ack in RUN is ignored; reset dropped mid-WAIT.
        reset_n        = 1'b0;
        cfg_max_cycles = '0;
        cfg_log_begin  = '0;
        cfg_log_end    = '0;
        tick();
        reset_n = 1'b1;
        tick();
        init_ack = 1'b1;
        tick();
        init_ack  = 1'b0;
        step_ack  = 1'b1;
        step_fail = 1'b1;
        tick();
        step_ack  = 1'b0;
        step_fail = 1'b0;
        check("stray.no_finish", finish, 0);
        check("stray.cycle1", cycle_count, 1);
        check("stray.no_req", step_req, 0);
        difftest_step = 2'b01;
        tick();
        difftest_step = 2'b00;
        tick();
        tick();
        check("w2.req", step_req, 1);
        check("w2.mask", step_mask, 2'b01);
        check("w2.cycle4", cycle_count, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        reset_n = 1'b1;
        tick();
        check("reinit.init_req", init_req, 1);
        check("reinit.stall", dut_stall, 1);
        check("reinit.step_req", step_req, 0);
        check("reinit.cycle", cycle_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/difftest_sim_ctrl.md
Name: difftest_sim_ctrl

Overview:
- Synthesisable simulation-control block for difftest runs on simulators and FPGA emulation.
- Sits between SimTop and an external checker (DPI shim or FPGA host link).
- Registers per-core difftest_step pulses and batches them into checker requests over a req/ack handshake.
- Stalls the DUT while a check is outstanding, and tracks cycles, log window, max-cycle timeout and finish status.

Parameters:
NUM_CORES, 1, number of difftest_step channels (1..16)
CYCLE_W, 64, cycle counter and config width
STALL_ON_PENDING, 1, 1 = assert dut_stall while a step request awaits ack; 0 = DUT free-runs and steps accumulate

Ports:
clock  input  1  clock
reset_n  input  1  asynchronous active-low reset
cfg_max_cycles  input  CYCLE_W  timeout limit; 0 = unlimited
cfg_log_begin  input  CYCLE_W  first logged cycle
cfg_log_end  input  CYCLE_W  first unlogged cycle; 0 = logging off
difftest_step  input  NUM_CORES  per-core commit-check pulse from DUT
init_req  output  1  checker initialisation request
init_ack  input  1  single-cycle init acknowledge
step_req  output  1  step-check request
step_mask  output  NUM_CORES  cores to check, stable while step_req=1
step_ack  input  1  single-cycle check done
step_fail  input  1  check result, valid with step_ack
dut_stall  output  1  DUT clock-enable low
log_enable  output  1  registered log window flag
cycle_count  output  CYCLE_W  DUT cycles elapsed
finish  output  1  sticky run-end flag
finish_code  output  2  0 running, 1 difftest fail, 2 timeout
fail_cycle  output  CYCLE_W  cycle_count latched at the failing request

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs and registers are 0; state is IDLE.
  - Any handshake in progress is dropped; the checker must discard it.
- States: IDLE, INIT, RUN, WAIT, DONE.
- IDLE -> INIT on the first clock after reset release.
- INIT:
  - init_req=1 and dut_stall=1.
  - On init_ack, go to RUN with init_req=0 on the next cycle.
- Handshake rules:
  - A request is held high until ack.
  - An ack without an outstanding request is ignored.
  - The ack cycle ends the request; a new request may start the following cycle.
- Step path:
  - step_dly <= difftest_step every cycle, giving a 1-cycle delay. It is cleared in reset and INIT.
  - pending <= pending | step_dly.
  - RUN with pending != 0: the next cycle has step_req=1, step_mask=pending, pending cleared, state WAIT, and req_cycle latched.
  - A step_dly arriving in that same cycle goes to pending, not the current mask.
  - WAIT: step_dly ORs into pending.
  - step_ack with step_fail=0 -> RUN. Remaining pending issues on the next RUN cycle, giving a minimum 2-cycle gap.
  - step_ack with step_fail=1 -> DONE, finish_code=1, fail_cycle=req_cycle.
- dut_stall:
  - 1 in INIT and DONE.
  - 1 in WAIT when STALL_ON_PENDING=1; otherwise 0.
  - With STALL_ON_PENDING=1, difftest_step arriving while stalled is still captured.
- cycle_count:
  - Increments in RUN/WAIT when dut_stall=0.
  - Saturates at all-ones.
- Timeout:
  - In RUN/WAIT, if cfg_max_cycles != 0 and cycle_count >= cfg_max_cycles -> DONE, finish_code=2.
  - A fail ack in the same cycle wins and gives code 1.
- DONE:
  - Sticky until reset; finish=1.
  - step_req and init_req are 0; late acks are ignored.
- log_enable is registered: (cfg_log_end != 0) && cycle_count >= cfg_log_begin && cycle_count < cfg_log_end.
- Config inputs are quasi-static and sampled every cycle.

Optional Feature:
SIM_CTRL_PERF_EN:
- When defined, adds outputs perf_stall_cycles[CYCLE_W] and perf_step_reqs[32].
  - perf_stall_cycles counts cycles with dut_stall=1 in WAIT.
  - perf_step_reqs counts issued step requests.
  - Both saturate and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package sim_ctrl_pkg holds:
  - state enum (IDLE, INIT, RUN, WAIT, DONE);
  - finish-code constants FIN_NONE=0, FIN_FAIL=1, FIN_TIMEOUT=2.
- One sub-module, difftest_step_accum (per-core delay register plus pending OR-accumulator with take/clear), parametrised by NUM_CORES.

Test Plan:
- Release reset, hold init_ack low 5 cycles then pulse -> init_req high for exactly those cycles, then RUN; cycle_count stays 0 through INIT.
- NUM_CORES=2: pulse step[0] at RUN cycle 3 -> step_req rises 2 cycles later with mask 01; ack after 4 cycles with fail=0 -> dut_stall high during WAIT, cycle_count frozen.
- During WAIT pulse step[1] then step[0] -> after ack, next request carries mask 11.
- cfg_max_cycles=10, no steps -> finish=1, finish_code=2 when cycle_count reaches 10; dut_stall=1 thereafter.
- Ack with step_fail=1 for the request issued at cycle 7 -> finish_code=1, fail_cycle=7; a later ack is ignored.
- Assert reset_n=0 mid-WAIT -> all outputs 0 immediately; after release the block re-enters INIT.
